// File: rtl/shift_tx.sv
// Parallel-to-serial transmitter: shifts one captured word out LSB- or MSB-first,
// emitting a shift strobe per bit for a downstream shift register.
module shift_tx #(
    parameter int WIDTH = 4,
    parameter int DIV   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             msb_first,
    output logic             ser_out,
    output logic             ser_sr,
    output logic             ser_sl,
    output logic             busy,
    output logic             done
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [WIDTH-1:0] data_reg;
    logic [WIDTH-1:0] data_ordered;
    logic             msb_reg;
    logic [BW-1:0]    bit_cnt_reg;
    logic [DW-1:0]    div_cnt_reg;
    logic             handshake;
    logic             bit_end;
    logic             frame_end;

    // Present the captured word in transmit order so bit_cnt indexes it directly.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_order
            assign data_ordered[gi] = msb_reg ? data_reg[WIDTH-1-gi] : data_reg[gi];
        end
    endgenerate

    assign handshake = (state_reg == S_IDLE) && in_valid && !clr;
    assign bit_end   = (state_reg == S_SHIFT) && (div_cnt_reg == DIV_LAST);
    assign frame_end = bit_end && (bit_cnt_reg == BIT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (in_valid) state_next = S_SHIFT;
            S_SHIFT: if (frame_end) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        if (clr) begin
            state_next = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_reg    <= '0;
            msb_reg     <= 1'b0;
            bit_cnt_reg <= '0;
            div_cnt_reg <= '0;
        end else if (clr) begin
            bit_cnt_reg <= '0;
            div_cnt_reg <= '0;
        end else if (handshake) begin
            data_reg    <= in_data;
            msb_reg     <= msb_first;
            bit_cnt_reg <= '0;
            div_cnt_reg <= '0;
        end else if (state_reg == S_SHIFT) begin
            if (bit_end) begin
                div_cnt_reg <= '0;
                // Hold on the final bit so the counter never wraps inside a frame.
                if (!frame_end) begin
                    bit_cnt_reg <= bit_cnt_reg + BW'(1);
                end
            end else begin
                div_cnt_reg <= div_cnt_reg + DW'(1);
            end
        end
    end

    always_comb begin
        in_ready = (state_reg == S_IDLE);
        busy     = (state_reg != S_IDLE);
        done     = (state_reg == S_DONE);
        ser_out  = 1'b0;
        ser_sr   = 1'b0;
        ser_sl   = 1'b0;
        if (state_reg == S_SHIFT) begin
            ser_out = data_ordered[bit_cnt_reg];
            ser_sr  = bit_end && !msb_reg;
            ser_sl  = bit_end && msb_reg;
        end
    end

endmodule

// File: tb/tb_shift_tx.sv
// Directed bench for shift_tx: a DIV=1 and a DIV=3 instance, each feeding a
// shift-register receiver whose contents are scored against queued words on done.
module tb_shift_tx;

    logic       clk;
    logic       rst_n;
    logic       clr_a, v_a, m_a, rdy_a, so_a, sr_a, sl_a, busy_a, done_a;
    logic [3:0] d_a;
    logic       clr_b, v_b, m_b, rdy_b, so_b, sr_b, sl_b, busy_b, done_b;
    logic [3:0] d_b;
    logic [3:0] rx_a, rx_b;
    logic [3:0] exp_q_a[$];
    logic [3:0] exp_q_b[$];
    int         total = 0;
    int         bad   = 0;

    shift_tx #(.WIDTH(4), .DIV(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .clr(clr_a), .in_valid(v_a), .in_ready(rdy_a),
        .in_data(d_a), .msb_first(m_a), .ser_out(so_a), .ser_sr(sr_a),
        .ser_sl(sl_a), .busy(busy_a), .done(done_a)
    );

    shift_tx #(.WIDTH(4), .DIV(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .clr(clr_b), .in_valid(v_b), .in_ready(rdy_b),
        .in_data(d_b), .msb_first(m_b), .ser_out(so_b), .ser_sr(sr_b),
        .ser_sl(sl_b), .busy(busy_b), .done(done_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Receiving registers: ser_out is ir on a right shift, il on a left shift.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_a <= 4'd0;
            rx_b <= 4'd0;
        end else begin
            if (sr_a)      rx_a <= {so_a, rx_a[3:1]};
            else if (sl_a) rx_a <= {rx_a[2:0], so_a};
            if (sr_b)      rx_b <= {so_b, rx_b[3:1]};
            else if (sl_b) rx_b <= {rx_b[2:0], so_b};
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Scoreboard side: pop one expected word per done pulse.
    always @(negedge clk) begin
        chk("excl_a", {31'd0, sr_a & sl_a}, 32'd0);
        chk("excl_b", {31'd0, sr_b & sl_b}, 32'd0);
        if (!busy_a || done_a) chk("quiet_a", {29'd0, so_a, sr_a, sl_a}, 32'd0);
        if (!busy_b || done_b) chk("quiet_b", {29'd0, so_b, sr_b, sl_b}, 32'd0);
        if (done_a) begin
            if (exp_q_a.size() == 0) chk("unexpected_done_a", {31'd0, done_a}, 32'd0);
            else begin
                logic [3:0] e;
                e = exp_q_a.pop_front();
                chk("rx_a", {28'd0, rx_a}, {28'd0, e});
                $display("word a rx=%h exp=%h", rx_a, e);
            end
        end
        if (done_b) begin
            if (exp_q_b.size() == 0) chk("unexpected_done_b", {31'd0, done_b}, 32'd0);
            else begin
                logic [3:0] e;
                e = exp_q_b.pop_front();
                chk("rx_b", {28'd0, rx_b}, {28'd0, e});
                $display("word b rx=%h exp=%h", rx_b, e);
            end
        end
    end

    // One DIV=1 frame, starting at a negedge with dut_a idle.
    task automatic frame_a(input logic [3:0] w, input logic m);
        logic eb;
        chk("ready_before_a", {31'd0, rdy_a}, 32'd1);
        exp_q_a.push_back(w);
        d_a = w; m_a = m; v_a = 1'b1;
        @(negedge clk);
        v_a = 1'b0; d_a = ~w; m_a = ~m;
        for (int k = 0; k < 4; k++) begin
            eb = m ? w[3-k] : w[k];
            chk("ser_out_a", {31'd0, so_a}, {31'd0, eb});
            chk("sr_a", {31'd0, sr_a}, {31'd0, !m});
            chk("sl_a", {31'd0, sl_a}, {31'd0, m});
            chk("busy_a", {31'd0, busy_a}, 32'd1);
            chk("done_early_a", {31'd0, done_a}, 32'd0);
            @(negedge clk);
        end
        chk("done_a", {31'd0, done_a}, 32'd1);
        chk("ready_in_done_a", {31'd0, rdy_a}, 32'd0);
        @(negedge clk);
        chk("ready_after_a", {31'd0, rdy_a}, 32'd1);
        chk("done_once_a", {31'd0, done_a}, 32'd0);
        chk("busy_after_a", {31'd0, busy_a}, 32'd0);
    endtask

    // One DIV=3 frame on dut_b.
    task automatic frame_b(input logic [3:0] w, input logic m);
        logic eb, st;
        int   idx;
        chk("ready_before_b", {31'd0, rdy_b}, 32'd1);
        exp_q_b.push_back(w);
        d_b = w; m_b = m; v_b = 1'b1;
        @(negedge clk);
        v_b = 1'b0; d_b = ~w; m_b = ~m;
        for (int c = 1; c <= 12; c++) begin
            idx = (c - 1) / 3;
            eb  = m ? w[3-idx] : w[idx];
            st  = (c % 3 == 0);
            chk("ser_out_b", {31'd0, so_b}, {31'd0, eb});
            chk("sr_b", {31'd0, sr_b}, {31'd0, st && !m});
            chk("sl_b", {31'd0, sl_b}, {31'd0, st && m});
            chk("done_early_b", {31'd0, done_b}, 32'd0);
            @(negedge clk);
        end
        chk("done_b", {31'd0, done_b}, 32'd1);
        @(negedge clk);
        chk("ready_after_b", {31'd0, rdy_b}, 32'd1);
        chk("done_once_b", {31'd0, done_b}, 32'd0);
    endtask

    initial begin
        int n;
        int strobes;
        rst_n = 1'b1;
        clr_a = 1'b0; v_a = 1'b0; m_a = 1'b0; d_a = 4'd0;
        clr_b = 1'b0; v_b = 1'b0; m_b = 1'b0; d_b = 4'd0;
        #2 rst_n = 1'b0;
        #2;
        chk("rst_ready_a", {31'd0, rdy_a}, 32'd1);
        chk("rst_outs_a", {28'd0, so_a, sr_a, sl_a, busy_a | done_a}, 32'd0);
        chk("rst_ready_b", {31'd0, rdy_b}, 32'd1);
        chk("rst_outs_b", {28'd0, so_b, sr_b, sl_b, busy_b | done_b}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        frame_a(4'b1011, 1'b0);
        frame_a(4'b1011, 1'b1);
        frame_b(4'b0110, 1'b0);
        frame_b(4'b1001, 1'b1);
        for (int i = 0; i < 4; i++) begin
            logic [3:0] rw;
            rw = 4'($urandom_range(0, 15));
            frame_a(rw, 1'($urandom_range(0, 1)));
        end

        // Back-to-back: in_valid stays high across two words.
        exp_q_a.push_back(4'hA);
        d_a = 4'hA; m_a = 1'b0; v_a = 1'b1;
        @(negedge clk);
        n = 1;
        d_a = 4'h5;
        while (!rdy_a && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_gap", n, 32'd6);
        exp_q_a.push_back(4'h5);
        @(negedge clk);
        v_a = 1'b0;
        n = 0;
        while (exp_q_a.size() != 0 && n < 12) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_drained", exp_q_a.size(), 32'd0);
        @(negedge clk);

        // Abort in SHIFT cycle 2.
        d_a = 4'hF; m_a = 1'b0; v_a = 1'b1;
        @(negedge clk);
        v_a = 1'b0;
        @(negedge clk);
        chk("clr_busy_before", {31'd0, busy_a}, 32'd1);
        clr_a = 1'b1;
        @(negedge clk);
        clr_a = 1'b0;
        chk("clr_ready", {31'd0, rdy_a}, 32'd1);
        chk("clr_outs", {28'd0, so_a, sr_a, sl_a, busy_a | done_a}, 32'd0);
        strobes = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            strobes += int'(sr_a) + int'(sl_a);
        end
        chk("clr_no_strobes", strobes, 32'd0);
        frame_a(4'b0011, 1'b1);

        // Asynchronous reset pulse mid-frame, between clock edges.
        d_a = 4'b1111; m_a = 1'b0; v_a = 1'b1;
        @(negedge clk);
        v_a = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ready", {31'd0, rdy_a}, 32'd1);
        chk("arst_outs", {28'd0, so_a, sr_a, sl_a, busy_a | done_a}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("arst_idle", {31'd0, busy_a}, 32'd0);
            @(negedge clk);
        end
        frame_a(4'b0110, 1'b0);

        chk("queue_a_empty", exp_q_a.size(), 32'd0);
        chk("queue_b_empty", exp_q_b.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shift_tx.md
SHIFT_TX -- requirements
Module: shift_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 4: parallel word width in bits, legal range 2..16.
REQ-002 SHALL have parameter DIV, default 1: clk cycles per serial bit, legal range 1..256.
REQ-003 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port clr  input  1  synchronous abort of the current frame.
REQ-006 SHALL have port in_valid  input  1  in_data/msb_first offered.
REQ-007 SHALL have port in_ready  output  1  block can accept a word.
REQ-008 SHALL have port in_data  input  WIDTH  word to serialize.
REQ-009 SHALL have port msb_first  input  1  0 = LSB first, 1 = MSB first.
REQ-010 SHALL have port ser_out  output  1  current serial bit; drives the receiving register's ir/il.
REQ-011 SHALL have port ser_sr  output  1  shift-right strobe for LSB-first frames; drives receiver sr.
REQ-012 SHALL have port ser_sl  output  1  shift-left strobe for MSB-first frames; drives receiver sl.
REQ-013 SHALL have port busy  output  1  frame in progress (SHIFT or DONE).
REQ-014 SHALL have port done  output  1  one-cycle end-of-frame pulse.

Function
REQ-015 SHALL implement an FSM with states IDLE, SHIFT and DONE.
REQ-016 SHALL derive every output from registered state only, with no combinational path from any input.
REQ-017 SHALL assert in_ready only in IDLE; handshake = in_valid && in_ready at a rising edge.
REQ-018 On a handshake, SHALL capture in_data and msb_first into internal registers, clear the bit and divide counters, and enter SHIFT.
REQ-019 SHALL ignore changes of in_data/msb_first after capture.
REQ-020 In SHIFT, SHALL drive ser_out with the selected bit: bit k for LSB-first, bit WIDTH-1-k for MSB-first, where k = bit count.
REQ-021 SHALL hold each bit DIV cycles and assert exactly one strobe in the last cycle of each bit period: ser_sr if LSB-first, else ser_sl.
REQ-022 SHALL never assert ser_sr and ser_sl in the same cycle.
REQ-023 SHALL assert no strobe outside SHIFT.
REQ-024 SHALL force ser_out to 0 outside SHIFT.
REQ-025 SHALL occupy exactly WIDTH*DIV SHIFT cycles, with the first handshake-following cycle as SHIFT cycle 1.
REQ-026 SHALL increment the bit count on each strobe and go SHIFT->DONE after the strobe for bit WIDTH-1.
REQ-027 In DONE, SHALL assert done for exactly one cycle and then return to IDLE, with in_ready high in the following cycle.
REQ-028 SHALL give a throughput of one word per WIDTH*DIV+2 cycles under back-to-back in_valid.
REQ-029 SHALL give clr priority over all else: from any state it returns to IDLE next cycle, with no strobe and no done pulse in that next cycle.
REQ-030 SHALL ignore a handshake on a cycle with clr=1; the word is not accepted.
REQ-031 SHALL assert busy exactly when the state is SHIFT or DONE.
REQ-032 SHALL size its counters as clog2 of their ranges, and SHALL wrap no counter during a frame.
REQ-033 SHALL deliver the original word into a WIDTH-bit receiving register that shifts on the strobes with ser_out as its serial input, after WIDTH strobes, in both bit orders.

Reset
REQ-034 While rst_n=0, SHALL hold state=IDLE, all counters and captured data =0, in_ready=1, and ser_out, ser_sr, ser_sl, busy, done =0.
REQ-035 On reset assertion mid-frame, SHALL abort the frame immediately, asynchronously, with no done pulse.
REQ-036 Reset release SHALL be synchronous to clk; the first handshake is possible on the first rising edge with rst_n=1.

Verification
REQ-037 SHALL be verified by: WIDTH=4, DIV=1, in_data=4'b1011, msb_first=0 -> ser_out 1,1,0,1 with ser_sr high in cycles 1-4, done in cycle 5, receiver register = 4'b1011.
REQ-038 SHALL be verified by: same word, msb_first=1 -> ser_out 1,0,1,1 with ser_sl high in cycles 1-4, ser_sr never high, receiver = 4'b1011.
REQ-039 SHALL be verified by: DIV=3, in_data=4'b0110, LSB-first -> each bit held 3 cycles, strobes in cycles 3,6,9,12, done in cycle 13, in_ready high in cycle 14.
REQ-040 SHALL be verified by: in_valid held high with 4'hA then 4'h5, DIV=1 -> second handshake exactly 6 cycles after the first, and both words received intact.
REQ-041 SHALL be verified by: clr=1 in SHIFT cycle 2 -> next cycle IDLE, in_ready=1, no further strobes, no done, and a new word is accepted normally afterwards.
REQ-042 SHALL be verified by: rst_n pulsed low mid-frame between clock edges -> all outputs 0 immediately and in_ready=1, with no done.
